pcie2fifo_rx: RTL and testbench

//  Receive-side counterpart of the PCIe TX inject path. Accepts TLPs from the 7-series PCIe core
//  RX AXI-stream (64-bit) and writes them beat-by-beat into the TLP FIFO that feeds the Ethernet

---
 rtl/pcie2fifo_rx_pkg.sv | 37 +++
 rtl/pcie2fifo_rx.sv | 139 +++++++++++++
 tb/tb_pcie2fifo_rx.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie2fifo_rx_pkg.sv
// Shared types for the 64-bit PCIe RX stream and the TLP FIFO word it feeds.
// Also holds the RX framing FSM states and a saturating counter helper.
package pcie2fifo_rx_pkg;

  localparam int TDATA64_W         = 64;
  localparam int TKEEP64_W         = TDATA64_W / 8;
  localparam int TUSER64_RX_W      = 22;
  localparam int TUSER_ERR_FWD     = 1;
  localparam int MAX_BEATS_DEFAULT = 66;
  localparam int BEAT_CNT_W        = 7;

  typedef logic                    pcie_tready64_t;
  typedef logic                    pcie_tvalid64_t;
  typedef logic                    pcie_tlast64_t;
  typedef logic [TKEEP64_W-1:0]    pcie_tkeep64_t;
  typedef logic [TDATA64_W-1:0]    pcie_tdata64_t;
  typedef logic [TUSER64_RX_W-1:0] pcie_tuser64_rx_t;

  typedef struct packed {
    pcie_tvalid64_t   tvalid;
    pcie_tlast64_t    tlast;
    pcie_tkeep64_t    tkeep;
    pcie_tdata64_t    tdata;
    pcie_tuser64_rx_t tuser;
  } pcie_fifo64_rx_t;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    DROP
  } rx_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/pcie2fifo_rx.sv
// Moves TLPs from the PCIe core RX AXI-stream into the TLP FIFO one beat per cycle,
// discarding poisoned TLPs and cutting oversize ones so every FIFO packet ends in tlast.
module pcie2fifo_rx
  import pcie2fifo_rx_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
  parameter int MAX_BEATS    = MAX_BEATS_DEFAULT,
  parameter bit DROP_ERR     = 1'b1
) (
  input  logic                    pcie_clk,
  input  logic                    pcie_rst,
  output logic                    pcie_tready,
  input  logic                    pcie_tvalid,
  input  logic                    pcie_tlast,
  input  logic [KEEP_WIDTH-1:0]   pcie_tkeep,
  input  logic [C_DATA_WIDTH-1:0] pcie_tdata,
  input  logic [TUSER64_RX_W-1:0] pcie_tuser,
  output logic                    wr_en,
  output pcie_fifo64_rx_t         din,
  input  logic                    prog_full,
  output logic [7:0]              wr_pktcount,
  output logic                    pkt_done,
  output logic [15:0]             drop_count,
  output logic [15:0]             trunc_count
);

  localparam logic [BEAT_CNT_W-1:0] LAST_CNT = BEAT_CNT_W'(MAX_BEATS - 1);

  rx_state_e               state_q, state_d;
  logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                    wr_en_q, wr_en_d;
  pcie_fifo64_rx_t         din_q, din_d;
  logic                    pkt_done_q, pkt_done_d;
  logic [7:0]              wr_pktcount_q, wr_pktcount_d;
  logic [15:0]             drop_count_q, drop_count_d;
  logic [15:0]             trunc_count_q, trunc_count_d;

  logic                    accept;
  logic                    poisoned;
  pcie_fifo64_rx_t         beat;

  // DROP swallows beats regardless of FIFO level since nothing is written there.
  assign pcie_tready = !pcie_rst && ((state_q == DROP) || !prog_full);
  assign accept      = pcie_tvalid && pcie_tready;
  assign poisoned    = DROP_ERR && pcie_tuser[TUSER_ERR_FWD];

  always_comb begin
    beat        = '0;
    beat.tvalid = 1'b1;
    beat.tlast  = pcie_tlast;
    beat.tkeep  = pcie_tkeep;
    beat.tdata  = pcie_tdata;
    beat.tuser  = pcie_tuser;
  end

  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    wr_en_d       = 1'b0;
    din_d         = din_q;
    pkt_done_d    = 1'b0;
    wr_pktcount_d = wr_pktcount_q;
    drop_count_d  = drop_count_q;
    trunc_count_d = trunc_count_q;

    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (poisoned) begin
            drop_count_d = sat_inc16(drop_count_q);
            if (!pcie_tlast) state_d = DROP;
          end else begin
            wr_en_d = 1'b1;
            din_d   = beat;
            if (pcie_tlast) begin
              wr_pktcount_d = wr_pktcount_q + 8'd1;
              pkt_done_d    = 1'b1;
            end else begin
              state_d    = PASS;
              beat_cnt_d = BEAT_CNT_W'(1);
            end
          end
        end
        PASS: begin
          wr_en_d    = 1'b1;
          din_d      = beat;
          beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
          if (pcie_tlast) begin
            wr_pktcount_d = wr_pktcount_q + 8'd1;
            pkt_done_d    = 1'b1;
            state_d       = IDLE;
          end else if (beat_cnt_q == LAST_CNT) begin
            // Close the FIFO packet here and discard the rest of the TLP.
            din_d.tlast   = 1'b1;
            wr_pktcount_d = wr_pktcount_q + 8'd1;
            pkt_done_d    = 1'b1;
            trunc_count_d = sat_inc16(trunc_count_q);
            state_d       = DROP;
          end
        end
        DROP: begin
          if (pcie_tlast) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) begin
      state_q       <= IDLE;
      beat_cnt_q    <= '0;
      wr_en_q       <= 1'b0;
      din_q         <= '0;
      pkt_done_q    <= 1'b0;
      wr_pktcount_q <= '0;
      drop_count_q  <= '0;
      trunc_count_q <= '0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      wr_en_q       <= wr_en_d;
      din_q         <= din_d;
      pkt_done_q    <= pkt_done_d;
      wr_pktcount_q <= wr_pktcount_d;
      drop_count_q  <= drop_count_d;
      trunc_count_q <= trunc_count_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign din         = din_q;
  assign pkt_done    = pkt_done_q;
  assign wr_pktcount = wr_pktcount_q;
  assign drop_count  = drop_count_q;
  assign trunc_count = trunc_count_q;

endmodule

// File: tb/tb_pcie2fifo_rx.sv
// Scoreboard bench for pcie2fifo_rx: dut_a uses the default 66-beat limit, dut_b a 4-beat limit.
// Stimulus pushes expected FIFO writes into per-DUT queues; a monitor pops them on every wr_en.
module tb_pcie2fifo_rx;
  import pcie2fifo_rx_pkg::*;

  typedef struct packed {
    pcie_fifo64_rx_t din;
    logic            done;
    logic [7:0]      cnt;
  } exp_t;

  logic             pcie_clk;
  logic             rst_a, rst_b;

  logic             tready_a, tvalid_a, tlast_a, wr_en_a, prog_full_a, pkt_done_a;
  logic [7:0]       tkeep_a, pktcount_a;
  logic [63:0]      tdata_a;
  logic [21:0]      tuser_a;
  pcie_fifo64_rx_t  din_a;
  logic [15:0]      drop_a, trunc_a;

  logic             tready_b, tvalid_b, tlast_b, wr_en_b, prog_full_b, pkt_done_b;
  logic [7:0]       tkeep_b, pktcount_b;
  logic [63:0]      tdata_b;
  logic [21:0]      tuser_b;
  pcie_fifo64_rx_t  din_b;
  logic [15:0]      drop_b, trunc_b;

  exp_t             exp_a[$];
  exp_t             exp_b[$];
  int               wr_cycles_a[$];
  int               vectors = 0;
  int               miscompares = 0;
  int               cyc = 0;
  int               last_acc = 0;
  int               first_acc = 0;
  int               stalls = 0;
  logic [7:0]       exp_cnt_a = 8'd0;
  logic [7:0]       exp_cnt_b = 8'd0;

  pcie2fifo_rx dut_a (
    .pcie_clk    (pcie_clk),
    .pcie_rst    (rst_a),
    .pcie_tready (tready_a),
    .pcie_tvalid (tvalid_a),
    .pcie_tlast  (tlast_a),
    .pcie_tkeep  (tkeep_a),
    .pcie_tdata  (tdata_a),
    .pcie_tuser  (tuser_a),
    .wr_en       (wr_en_a),
    .din         (din_a),
    .prog_full   (prog_full_a),
    .wr_pktcount (pktcount_a),
    .pkt_done    (pkt_done_a),
    .drop_count  (drop_a),
    .trunc_count (trunc_a)
  );

  pcie2fifo_rx #(.MAX_BEATS(4)) dut_b (
    .pcie_clk    (pcie_clk),
    .pcie_rst    (rst_b),
    .pcie_tready (tready_b),
    .pcie_tvalid (tvalid_b),
    .pcie_tlast  (tlast_b),
    .pcie_tkeep  (tkeep_b),
    .pcie_tdata  (tdata_b),
    .pcie_tuser  (tuser_b),
    .wr_en       (wr_en_b),
    .din         (din_b),
    .prog_full   (prog_full_b),
    .wr_pktcount (pktcount_b),
    .pkt_done    (pkt_done_b),
    .drop_count  (drop_b),
    .trunc_count (trunc_b)
  );

  initial begin
    pcie_clk = 1'b0;
    forever #5 pcie_clk = ~pcie_clk;
  end

  initial forever begin
    @(posedge pcie_clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] beatData(input int id, input int b);
    return {16'hC0DE, 16'(id), 32'(b)};
  endfunction

  function automatic logic [7:0] keepOf(input int b, input int n);
    return (b == n - 1) ? 8'h0F : 8'hFF;
  endfunction

  task automatic expectBeat(input bit sel, input logic [63:0] data, input logic [7:0] keep,
                            input logic [21:0] user, input logic last, input logic done);
    exp_t e;
    e.din.tvalid = 1'b1;
    e.din.tlast  = last;
    e.din.tkeep  = keep;
    e.din.tdata  = data;
    e.din.tuser  = user;
    e.done       = done;
    if (!sel) begin
      if (done) exp_cnt_a = exp_cnt_a + 8'd1;
      e.cnt = exp_cnt_a;
      exp_a.push_back(e);
    end else begin
      if (done) exp_cnt_b = exp_cnt_b + 8'd1;
      e.cnt = exp_cnt_b;
      exp_b.push_back(e);
    end
  endtask

  task automatic driveInputs(input bit sel, input logic [63:0] data, input logic [7:0] keep,
                             input logic [21:0] user, input logic last);
    if (!sel) begin
      tvalid_a = 1'b1; tdata_a = data; tkeep_a = keep; tuser_a = user; tlast_a = last;
    end else begin
      tvalid_b = 1'b1; tdata_b = data; tkeep_b = keep; tuser_b = user; tlast_b = last;
    end
  endtask

  // Presents one beat and returns just after the edge that accepted it.
  task automatic applyStimulus(input bit sel, input logic [63:0] data, input logic [7:0] keep,
                               input logic [21:0] user, input logic last);
    int  waits = 0;
    bit  taken = 1'b0;
    bit  done  = 1'b0;
    driveInputs(sel, data, keep, user, last);
    while (!done) begin
      @(negedge pcie_clk);
      taken = sel ? tready_b : tready_a;
      @(posedge pcie_clk);
      #1;
      if (taken) begin
        done = 1'b1;
      end else begin
        waits++;
        stalls++;
        if (waits > 100) begin
          checkOutput("accept_timeout", 128'(waits), 128'(0));
          done = 1'b1;
        end
      end
    end
    last_acc = cyc;
  endtask

  task automatic sendCleanTlp(input bit sel, input int id, input int n);
    for (int b = 0; b < n; b++) begin
      expectBeat(sel, beatData(id, b), keepOf(b, n), 22'h4, b == n - 1, b == n - 1);
      applyStimulus(sel, beatData(id, b), keepOf(b, n), 22'h4, b == n - 1);
      if (b == 0) first_acc = last_acc;
    end
  endtask

  task automatic drain();
    tvalid_a = 1'b0; tlast_a = 1'b0;
    tvalid_b = 1'b0; tlast_b = 1'b0;
    repeat (3) @(posedge pcie_clk);
    #1;
  endtask

  // Monitor: every FIFO write must match the head of that DUT's expected queue.
  initial forever begin
    exp_t e;
    @(negedge pcie_clk);
    if (wr_en_a) begin
      wr_cycles_a.push_back(cyc);
      if (exp_a.size() == 0) checkOutput("a_unexpected_write", 128'(wr_en_a), 128'(1'b0));
      else begin
        e = exp_a.pop_front();
        checkOutput("a_write", 128'({din_a, pkt_done_a, pktcount_a}), 128'(e));
      end
    end else if (pkt_done_a) checkOutput("a_stray_pkt_done", 128'(pkt_done_a), 128'(1'b0));
    if (wr_en_b) begin
      if (exp_b.size() == 0) checkOutput("b_unexpected_write", 128'(wr_en_b), 128'(1'b0));
      else begin
        e = exp_b.pop_front();
        checkOutput("b_write", 128'({din_b, pkt_done_b, pktcount_b}), 128'(e));
      end
    end else if (pkt_done_b) checkOutput("b_stray_pkt_done", 128'(pkt_done_b), 128'(1'b0));
  end

  initial begin
    int idx;
    rst_a = 1'b1; rst_b = 1'b1;
    tvalid_a = 1'b0; tlast_a = 1'b0; tkeep_a = '0; tdata_a = '0; tuser_a = '0; prog_full_a = 1'b0;
    tvalid_b = 1'b0; tlast_b = 1'b0; tkeep_b = '0; tdata_b = '0; tuser_b = '0; prog_full_b = 1'b0;
    repeat (3) @(posedge pcie_clk);
    @(negedge pcie_clk);
    checkOutput("rst_tready_a", 128'(tready_a), 128'(1'b0));
    checkOutput("rst_tready_b", 128'(tready_b), 128'(1'b0));
    checkOutput("rst_wr_en", 128'(wr_en_a), 128'(1'b0));
    checkOutput("rst_din", 128'(din_a), 128'(0));
    checkOutput("rst_pkt_done", 128'(pkt_done_a), 128'(1'b0));
    checkOutput("rst_pktcount", 128'(pktcount_a), 128'(0));
    checkOutput("rst_drop", 128'(drop_a), 128'(0));
    checkOutput("rst_trunc", 128'(trunc_a), 128'(0));
    @(posedge pcie_clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    checkOutput("idle_tready", 128'(tready_a), 128'(1'b1));

    $display("[TB] 3-beat TLP");
    idx = wr_cycles_a.size();
    sendCleanTlp(0, 1, 3);
    drain();
    checkOutput("t1_writes", 128'(wr_cycles_a.size() - idx), 128'(3));
    if (wr_cycles_a.size() >= idx + 3) begin
      checkOutput("t1_first_latency", 128'(wr_cycles_a[idx]), 128'(first_acc));
      checkOutput("t1_last_latency", 128'(wr_cycles_a[idx+2]), 128'(first_acc + 2));
    end
    checkOutput("t1_pktcount", 128'(pktcount_a), 128'(1));

    $display("[TB] ten back-to-back 1-beat TLPs");
    idx = wr_cycles_a.size();
    stalls = 0;
    for (int i = 0; i < 10; i++) sendCleanTlp(0, 20 + i, 1);
    drain();
    checkOutput("t2_stalls", 128'(stalls), 128'(0));
    checkOutput("t2_writes", 128'(wr_cycles_a.size() - idx), 128'(10));
    if (wr_cycles_a.size() >= idx + 10)
      checkOutput("t2_span", 128'(wr_cycles_a[idx+9] - wr_cycles_a[idx]), 128'(9));
    checkOutput("t2_pktcount", 128'(pktcount_a), 128'(11));

    $display("[TB] prog_full stall mid-packet");
    idx = wr_cycles_a.size();
    for (int b = 0; b < 5; b++) expectBeat(0, beatData(40, b), keepOf(b, 5), 22'h0, b == 4, b == 4);
    applyStimulus(0, beatData(40, 0), keepOf(0, 5), 22'h0, 1'b0);
    applyStimulus(0, beatData(40, 1), keepOf(1, 5), 22'h0, 1'b0);
    prog_full_a = 1'b1;
    driveInputs(0, beatData(40, 2), keepOf(2, 5), 22'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge pcie_clk);
      checkOutput("t3_tready_stalled", 128'(tready_a), 128'(1'b0));
      @(posedge pcie_clk);
      #1;
    end
    prog_full_a = 1'b0;
    for (int b = 2; b < 5; b++) applyStimulus(0, beatData(40, b), keepOf(b, 5), 22'h0, b == 4);
    drain();
    checkOutput("t3_writes", 128'(wr_cycles_a.size() - idx), 128'(5));
    checkOutput("t3_pktcount", 128'(pktcount_a), 128'(12));

    $display("[TB] poisoned TLPs");
    applyStimulus(0, beatData(50, 0), 8'hFF, 22'h2, 1'b0);
    prog_full_a = 1'b1;
    #1;
    checkOutput("t4_drop_tready", 128'(tready_a), 128'(1'b1));
    for (int b = 1; b < 4; b++) applyStimulus(0, beatData(50, b), keepOf(b, 4), 22'h0, b == 3);
    prog_full_a = 1'b0;
    sendCleanTlp(0, 51, 2);
    drain();
    checkOutput("t4_drop_count", 128'(drop_a), 128'(1));
    checkOutput("t4_pktcount", 128'(pktcount_a), 128'(13));
    applyStimulus(0, beatData(52, 0), 8'h0F, 22'h2, 1'b1);
    sendCleanTlp(0, 53, 1);
    drain();
    checkOutput("t4_drop_single", 128'(drop_a), 128'(2));
    checkOutput("t4_pktcount_single", 128'(pktcount_a), 128'(14));
    for (int b = 0; b < 3; b++) begin
      expectBeat(0, beatData(54, b), keepOf(b, 3), (b == 1) ? 22'h2 : 22'h0, b == 2, b == 2);
      applyStimulus(0, beatData(54, b), keepOf(b, 3), (b == 1) ? 22'h2 : 22'h0, b == 2);
    end
    drain();
    checkOutput("t4_late_err_kept", 128'(drop_a), 128'(2));
    checkOutput("t4_late_err_pkt", 128'(pktcount_a), 128'(15));

    $display("[TB] 66-beat limit on dut_a");
    for (int b = 0; b < 66; b++)
      expectBeat(0, beatData(60, b), keepOf(b, 67), 22'h0, b == 65, b == 65);
    for (int b = 0; b < 67; b++) applyStimulus(0, beatData(60, b), keepOf(b, 67), 22'h0, b == 66);
    sendCleanTlp(0, 61, 66);
    drain();
    checkOutput("t5a_trunc", 128'(trunc_a), 128'(1));
    checkOutput("t5a_pktcount", 128'(pktcount_a), 128'(17));

    $display("[TB] 4-beat limit on dut_b");
    for (int b = 0; b < 4; b++) expectBeat(1, beatData(70, b), 8'hFF, 22'h0, b == 3, b == 3);
    for (int b = 0; b < 6; b++) applyStimulus(1, beatData(70, b), keepOf(b, 6), 22'h0, b == 5);
    sendCleanTlp(1, 71, 4);
    drain();
    checkOutput("t5b_trunc", 128'(trunc_b), 128'(1));
    checkOutput("t5b_pktcount", 128'(pktcount_b), 128'(2));

    $display("[TB] reset mid-packet then 257 TLPs");
    expectBeat(0, beatData(80, 0), 8'hFF, 22'h0, 1'b0, 1'b0);
    applyStimulus(0, beatData(80, 0), 8'hFF, 22'h0, 1'b0);
    driveInputs(0, beatData(80, 1), 8'hFF, 22'h0, 1'b0);
    rst_a = 1'b1;
    @(negedge pcie_clk);
    checkOutput("t6_rst_tready", 128'(tready_a), 128'(1'b0));
    @(posedge pcie_clk);
    #1;
    tvalid_a = 1'b0;
    @(negedge pcie_clk);
    checkOutput("t6_rst_wr_en", 128'(wr_en_a), 128'(1'b0));
    checkOutput("t6_rst_pktcount", 128'(pktcount_a), 128'(0));
    checkOutput("t6_rst_drop", 128'(drop_a), 128'(0));
    checkOutput("t6_rst_trunc", 128'(trunc_a), 128'(0));
    @(posedge pcie_clk);
    #1;
    rst_a = 1'b0;
    exp_cnt_a = 8'd0;
    for (int i = 0; i < 257; i++) sendCleanTlp(0, 100 + i, 1);
    drain();
    checkOutput("t6_pktcount_wrap", 128'(pktcount_a), 128'(1));
    checkOutput("exp_a_empty", 128'(exp_a.size()), 128'(0));
    checkOutput("exp_b_empty", 128'(exp_b.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
